approx_add_pipe: RTL and testbench
==================================

Name: approx_add_pipe

Overview:
- Parametrised, pipelined lower-part-OR approximate unsigned adder.
- Generalises the fixed 8-bit approximate adder in three ways: width is a parameter, the approximation depth k is selected per transaction at run time, and the output stream is elastic (valid/ready).
- Carries an exact reference sum alongside each result and feeds an on-line error monitor (transaction count, error count, accumulated and maximum |error|).
- Sits between operand producers and accuracy-characterisation or datapath consumers.

Parameters:
- W, 8: operand width; sum is W+1 bits.
- MAX_K, 4: maximum number of approximate LSBs, 0 ≤ MAX_K < W.
- KW, 3: width of in_k; 2^KW > MAX_K.
- STAGES, 2: register stages from input to output, ≥1.
- CNT_W, 16: width of the transaction and error counters.
- ACC_W, 24: width of the |error| accumulator.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block accepts the transaction this cycle.
- in_a  in  W  operand A, unsigned.
- in_b  in  W  operand B, unsigned.
- in_k  in  KW  approximate LSB count for this transaction.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W+1  approximate sum.
- out_err  out  MAX_K+1  signed error, approx minus exact, two's complement.
- stats_clr  in  1  synchronous clear of all statistics.
- stat_txn  out  CNT_W  results delivered.
- stat_errcnt  out  CNT_W  delivered results with out_err ≠ 0.
- stat_abs_acc  out  ACC_W  sum of |out_err|.
- stat_max_abs  out  MAX_K  maximum |out_err|.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, out_valid=0, out_sum=0, out_err=0, all stat_* = 0. in_ready=1 once reset deasserts.
- Effective k: ke = min(in_k, MAX_K), sampled at acceptance (in_valid & in_ready). Out-of-range in_k is clamped, not flagged.
- Arithmetic:
  - Bits i < ke: sum[i] = a[i] | b[i].
  - Carry into bit ke: c = a[ke-1] & b[ke-1] if ke ≥ 1, otherwise 0.
  - Bits ≥ ke: exact sum of a[W-1:ke] + b[W-1:ke] + c, placed at bit ke and up, including the carry-out at bit W.
  - ke = 0 gives the exact adder.
- Error: exact = a + b, err = approx − exact.
  - err lies in [−(2^ke − 1), +2^(ke−1)].
  - It fits MAX_K+1 bits, and |err| fits MAX_K bits.
- Pipeline:
  - Result and err are computed combinationally at input and then carried through STAGES registers.
  - Latency is exactly STAGES cycles from acceptance to out_valid when out_ready is held high.
  - Stage j loads when it is empty or when stage j+1 loads / the output is taken.
  - in_ready = stage 0 empty OR stage 0 advancing.
  - Full throughput is 1 transaction per cycle. No bubbles are inserted under continuous ready.
  - Output data is held stable while out_valid=1 and out_ready=0. Ordering is preserved and nothing is dropped or duplicated.
- Statistics update only on output handshake (out_valid & out_ready):
  - stat_txn increments by 1.
  - stat_errcnt increments by 1 if err ≠ 0.
  - stat_abs_acc adds |err|.
  - stat_max_abs = max(stat_max_abs, |err|).
  - All counters and the accumulator saturate at all-ones and never wrap.
- stats_clr: the next state of all stat_* is 0.
  - If a handshake occurs in the same cycle, clear wins and that transaction is not counted.
  - stats_clr does not affect the pipeline.
- Reset mid-operation discards all in-flight transactions. No output follows reset until new input is accepted.

Test Plan:
- W=8, ke=0, a=0xFF, b=0xFF -> out_sum=0x1FE, out_err=0 after exactly 2 cycles; stat_txn=1, stat_errcnt=0.
- ke=4, a=0x0F, b=0x01 -> out_sum=0x00F, out_err=−1; ke=4, a=0x08, b=0x08 -> out_sum=0x018, exact 0x010, out_err=+8; afterwards stat_abs_acc=9, stat_max_abs=8, stat_errcnt=2.
- in_k=7 with MAX_K=4, a=0x13, b=0x11 -> treated as ke=4: out_sum=0x023, out_err=−1.
- Back-to-back stream of 100 random operands with out_ready toggling on a 3-on/2-off pattern -> all 100 results delivered in order, each matching the golden model; data stable while stalled; stat_txn=100.
- Saturation: CNT_W=4 build, 20 transactions -> stat_txn=15. Assert stats_clr in the same cycle as a handshake -> all stat_* read 0 on the next cycle.
- Assert rst_n low while 2 transactions are in flight -> out_valid=0 and all stat_*=0 immediately (asynchronous); no stale output after release.

Source files
------------

// File: rtl/approx_add_pipe_if.sv
// Operand/result stream bundle for approx_add_pipe: valid/ready on both sides.
interface approx_add_pipe_if #(
  parameter int W     = 8,
  parameter int MAX_K = 4,
  parameter int KW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [KW-1:0]    in_k;
  logic             out_valid;
  logic             out_ready;
  logic [W:0]       out_sum;
  logic [MAX_K:0]   out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_k, out_ready,
    output in_ready, out_valid, out_sum, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_k, out_ready,
    input  in_ready, out_valid, out_sum, out_err
  );
endinterface

// File: rtl/approx_add_pipe.sv
// Pipelined lower-part-OR approximate adder with run-time depth, elastic output
// and an on-line error monitor fed by the delivered results.
module approx_add_pipe #(
  parameter int W      = 8,
  parameter int MAX_K  = 4,
  parameter int KW     = 3,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  approx_add_pipe_if.slave    bus,
  input  logic                stats_clr,
  output logic [CNT_W-1:0]    stat_txn,
  output logic [CNT_W-1:0]    stat_errcnt,
  output logic [ACC_W-1:0]    stat_abs_acc,
  output logic [MAX_K-1:0]    stat_max_abs
);

  typedef struct packed {
    logic [W:0]     sum;
    logic [MAX_K:0] err;
  } res_t;

  localparam logic [KW-1:0] KMAX = KW'(MAX_K);

  // ---------------- input-side arithmetic ----------------
  logic [KW-1:0]  ke;
  logic [W-1:0]   ab_and_sh;
  logic           c;
  logic [W:0]     lo_mask, up_sum, ap_sum, ex_sum;
  logic [W+1:0]   diff;
  res_t           in_res;

  always_comb begin
    ke        = (bus.in_k > KMAX) ? KMAX : bus.in_k;
    lo_mask   = ~({(W+1){1'b1}} << ke);
    // carry into bit ke comes from the AND of the top approximate bit pair
    ab_and_sh = (bus.in_a & bus.in_b) >> (ke - KW'(1));
    c         = (ke != '0) & ab_and_sh[0];
    up_sum    = (({1'b0, bus.in_a} >> ke) + ({1'b0, bus.in_b} >> ke) + (W+1)'(c)) << ke;
    ap_sum    = up_sum | ({1'b0, bus.in_a | bus.in_b} & lo_mask);
    ex_sum    = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    diff      = {1'b0, ap_sum} - {1'b0, ex_sum};
    in_res.sum = ap_sum;
    in_res.err = diff[MAX_K:0];
  end

  // ---------------- elastic pipeline ----------------
  logic [STAGES-1:0] vld_pipe;
  logic [STAGES-1:0] adv;
  res_t              data_q [STAGES];

  // A stage advances when the output is taken or any stage at/after it is empty.
  always_comb begin
    adv = '0;
    for (int j = 0; j < STAGES; j++) begin
      adv[j] = bus.out_ready;
      for (int m = j; m < STAGES; m++)
        if (!vld_pipe[m]) adv[j] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int j = 0; j < STAGES; j++) data_q[j] <= '0;
    end else begin
      if (adv[0]) begin
        vld_pipe[0] <= bus.in_valid;
        if (bus.in_valid) data_q[0] <= in_res;
      end
      for (int j = 1; j < STAGES; j++) begin
        if (adv[j]) begin
          vld_pipe[j] <= vld_pipe[j-1];
          if (vld_pipe[j-1]) data_q[j] <= data_q[j-1];
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld_pipe[STAGES-1];
  assign bus.out_sum   = data_q[STAGES-1].sum;
  assign bus.out_err   = data_q[STAGES-1].err;

  // ---------------- error statistics ----------------
  logic             hs;
  logic [MAX_K:0]   neg_err;
  logic [MAX_K-1:0] abs_err;
  logic [ACC_W:0]   acc_sum;

  always_comb begin
    hs      = bus.out_valid & bus.out_ready;
    neg_err = -bus.out_err;
    abs_err = bus.out_err[MAX_K] ? neg_err[MAX_K-1:0] : bus.out_err[MAX_K-1:0];
    acc_sum = {1'b0, stat_abs_acc} + (ACC_W+1)'(abs_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_txn     <= '0;
      stat_errcnt  <= '0;
      stat_abs_acc <= '0;
      stat_max_abs <= '0;
    end else if (stats_clr) begin
      stat_txn     <= '0;
      stat_errcnt  <= '0;
      stat_abs_acc <= '0;
      stat_max_abs <= '0;
    end else if (hs) begin
      if (!(&stat_txn)) stat_txn <= stat_txn + CNT_W'(1);
      if ((bus.out_err != '0) && !(&stat_errcnt)) stat_errcnt <= stat_errcnt + CNT_W'(1);
      stat_abs_acc <= acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
      if (abs_err > stat_max_abs) stat_max_abs <= abs_err;
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Scoreboard bench for approx_add_pipe: driver pushes expectations, monitor pops on handshake.
module tb_approx_add_pipe;

  localparam int W = 8, MAX_K = 4, KW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic stats_clr, stats_clr2;
  logic [15:0] stat_txn, stat_errcnt;
  logic [23:0] stat_abs_acc;
  logic [3:0]  stat_max_abs;
  logic [3:0]  stat_txn2, stat_errcnt2;
  logic [5:0]  stat_abs_acc2;
  logic [3:0]  stat_max_abs2;

  always #5 clk = ~clk;

  approx_add_pipe_if #(.W(W), .MAX_K(MAX_K), .KW(KW)) bus ();
  approx_add_pipe_if #(.W(W), .MAX_K(MAX_K), .KW(KW)) bus2 ();

  approx_add_pipe #(.W(W), .MAX_K(MAX_K), .KW(KW), .STAGES(2), .CNT_W(16), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stats_clr(stats_clr),
    .stat_txn(stat_txn), .stat_errcnt(stat_errcnt),
    .stat_abs_acc(stat_abs_acc), .stat_max_abs(stat_max_abs)
  );

  approx_add_pipe #(.W(W), .MAX_K(MAX_K), .KW(KW), .STAGES(2), .CNT_W(4), .ACC_W(6)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .stats_clr(stats_clr2),
    .stat_txn(stat_txn2), .stat_errcnt(stat_errcnt2),
    .stat_abs_acc(stat_abs_acc2), .stat_max_abs(stat_max_abs2)
  );

  typedef struct { int sum; int err; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int m_txn = 0, m_errcnt = 0, m_acc = 0, m_max = 0;
  bit rdy_mode = 0;
  int phase = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: split each operand at 2^ke, OR the low parts, add the high parts plus the carry.
  task automatic model(input int a, input int b, input int k, output int s, output int e);
    int ke, p, c;
    ke = (k > MAX_K) ? MAX_K : k;
    p  = 1 << ke;
    c  = (ke > 0) ? (((a >> (ke - 1)) & 1) & ((b >> (ke - 1)) & 1)) : 0;
    s  = (a / p + b / p + c) * p + ((a | b) % p);
    e  = s - (a + b);
  endtask

  task automatic send(input int a, input int b, input int k, input int s, input int e);
    bit acc;
    exp_t x;
    bus.in_a = a[W-1:0];
    bus.in_b = b[W-1:0];
    bus.in_k = k[KW-1:0];
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for a=%0d b=%0d", a, b);
    end else begin
      x.sum = s; x.err = e;
      sb.push_back(x);
    end
  endtask

  task automatic send_rand();
    int a, b, k, s, e;
    a = int'($urandom_range(0, 255));
    b = int'($urandom_range(0, 255));
    k = int'($urandom_range(0, 7));
    model(a, b, k, s, e);
    send(a, b, k, s, e);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && !bus.out_valid) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: %0d results outstanding", sb.size());
  endtask

  // 3-on / 2-off consumer pattern, changed well away from both clock edges
  always @(posedge clk) begin
    #2;
    if (rdy_mode) begin
      bus.out_ready = (phase < 3);
      phase = (phase + 1) % 5;
    end
  end

  // Monitor: compare every delivered result and track expected statistics
  logic [W:0]     held_sum;
  logic [MAX_K:0] held_err;
  bit             stalled = 0;

  always @(negedge clk) begin
    exp_t x;
    logic signed [MAX_K:0] oe;
    int ae;
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        checks++;
        if (!bus.out_valid || bus.out_sum !== held_sum || bus.out_err !== held_err) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b sum=%h err=%h held sum=%h err=%h",
                   bus.out_valid, bus.out_sum, bus.out_err, held_sum, held_err);
        end
      end
      stalled = 0;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        oe = bus.out_err;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: sum=%h with empty scoreboard", bus.out_sum);
        end else begin
          x = sb.pop_front();
          if (int'(bus.out_sum) != x.sum || int'(oe) != x.err) begin
            errors++;
            $display("FAIL result: sum=%0h err=%0d expected sum=%0h err=%0d",
                     bus.out_sum, int'(oe), x.sum, x.err);
          end
          if (!stats_clr) begin
            ae = (x.err < 0) ? -x.err : x.err;
            m_txn++;
            if (x.err != 0) m_errcnt++;
            m_acc += ae;
            if (ae > m_max) m_max = ae;
          end
        end
      end else if (bus.out_valid) begin
        stalled  = 1;
        held_sum = bus.out_sum;
        held_err = bus.out_err;
      end
      if (stats_clr) begin
        m_txn = 0; m_errcnt = 0; m_acc = 0; m_max = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stats_clr = 1'b0; stats_clr2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_k = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_k = '0; bus2.out_ready = 1'b1;
    #3;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sum", int'(bus.out_sum), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    chk("rst_stat_txn", int'(stat_txn), 0);
    chk("rst_stat_acc", int'(stat_abs_acc), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);

    // exact adder, latency
    send(8'hFF, 8'hFF, 0, 9'h1FE, 0);
    chk("lat_cycle1_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("lat_cycle2_valid", int'(bus.out_valid), 1);
    drain();
    chk("t1_txn", int'(stat_txn), 1);
    chk("t1_errcnt", int'(stat_errcnt), 0);

    // approximate cases, negative and positive error
    send(8'h0F, 8'h01, 4, 9'h00F, -1);
    send(8'h08, 8'h08, 4, 9'h018, 8);
    drain();
    chk("t2_txn", int'(stat_txn), 3);
    chk("t2_errcnt", int'(stat_errcnt), 2);
    chk("t2_acc", int'(stat_abs_acc), 9);
    chk("t2_max", int'(stat_max_abs), 8);

    // out-of-range k clamps to MAX_K
    send(8'h13, 8'h11, 7, 9'h023, -1);
    drain();
    chk("t3_errcnt", int'(stat_errcnt), 3);
    chk("t3_acc", int'(stat_abs_acc), 10);

    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    chk("clr_txn", int'(stat_txn), 0);
    chk("clr_max", int'(stat_max_abs), 0);

    // random stream with a stalling consumer
    rdy_mode = 1;
    for (int i = 0; i < 100; i++) send_rand();
    drain();
    rdy_mode = 0;
    bus.out_ready = 1'b1;
    chk("rand_txn", int'(stat_txn), 100);
    chk("rand_errcnt", int'(stat_errcnt), m_errcnt);
    chk("rand_acc", int'(stat_abs_acc), m_acc);
    chk("rand_max", int'(stat_max_abs), m_max);

    // asynchronous reset with two results in flight
    bus.out_ready = 1'b0;
    send_rand();
    send_rand();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_txn", int'(stat_txn), 0);
    chk("arst_errcnt", int'(stat_errcnt), 0);
    chk("arst_acc", int'(stat_abs_acc), 0);
    chk("arst_max", int'(stat_max_abs), 0);
    sb.delete();
    m_txn = 0; m_errcnt = 0; m_acc = 0; m_max = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_output", int'(bus.out_valid), 0);
    end

    // clear in the same cycle as a handshake
    bus.out_ready = 1'b0;
    send(8'h0F, 8'h01, 4, 9'h00F, -1);
    for (int i = 0; i < 10 && !bus.out_valid; i++) begin @(posedge clk); #1; end
    chk("clrhs_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    chk("clrhs_txn", int'(stat_txn), 0);
    chk("clrhs_errcnt", int'(stat_errcnt), 0);
    chk("clrhs_acc", int'(stat_abs_acc), 0);
    chk("clrhs_max", int'(stat_max_abs), 0);
    drain();

    // saturation on the narrow-counter build: 20 results of err=+8
    bus2.in_a = 8'h08; bus2.in_b = 8'h08; bus2.in_k = 3'd4;
    bus2.in_valid = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    bus2.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("sat_txn", int'(stat_txn2), 15);
    chk("sat_errcnt", int'(stat_errcnt2), 15);
    chk("sat_acc", int'(stat_abs_acc2), 63);
    chk("sat_max", int'(stat_max_abs2), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
